// File: rtl/digit_scan_controller_if.sv
// Display-side bus of the digit scanner: BCD value/load/brightness controls in,
// registered SEG/DIGIT drive and frame marker out.
interface digit_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [2:0]              bright;
  logic                    lzs_en;
  logic [6:0]              SEG;
  logic [NUM_DIGITS-1:0]   DIGIT;
  logic                    frame_done;

  modport master (output value, load, bright, lzs_en,
                  input  SEG, DIGIT, frame_done);
  modport slave  (input  value, load, bright, lzs_en,
                  output SEG, DIGIT, frame_done);
endinterface

// File: rtl/digit_scan_controller.sv
// Multiplexed 7-segment scanner: per-frame BCD snapshot, blank/dwell slot per digit,
// PWM brightness, leading-zero blanking, frame_done on the last lit cycle.
module digit_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic CLK,
  input  logic RESET_N,
  digit_scan_controller_if.slave bus
);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW_W    = $clog2(DWELL_CYCLES);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int VW      = 4*NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS-1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES-1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES-1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [VW-1:0]         shadow_q;
  logic [VW-1:0]         snap_q, snap_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic                  fd_q, fd_d;

  logic [3:0] nib;
  logic       lead0;
  logic       zero_run;
  logic       lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_BLANK: if (cnt_q == BLANK_LAST) begin
        cnt_d   = '0;
        state_d = S_ON;
      end
      default: if (cnt_q == DWELL_LAST) begin
        cnt_d   = '0;
        state_d = S_BLANK;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    endcase

    // Snapshot is taken in the first cycle of every frame, so the whole frame
    // decodes one coherent value; the decoder looks at the post-capture value.
    snap_d = (state_q == S_BLANK && idx_q == '0 && cnt_q == '0) ? shadow_q : snap_q;

    nib      = '0;
    lead0    = 1'b0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      zero_run = zero_run & (snap_d[4*i +: 4] == 4'd0);
      if (idx_d == IDX_W'(i)) begin
        nib   = snap_d[4*i +: 4];
        lead0 = zero_run && (i != 0);
      end
    end

    lit = (cnt_d[DW_W-1 -: 3] <= bus.bright);

    seg_d   = '0;
    digit_d = '0;
    fd_d    = 1'b0;
    if (state_d == S_ON) begin
      digit_d = NUM_DIGITS'(1) << idx_d;
      if (lit && !(bus.lzs_en && lead0))
        seg_d = seg_decode(nib);
      fd_d = (idx_d == LAST_IDX) && (cnt_d == DWELL_LAST);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_BLANK;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      snap_q   <= '0;
      seg_q    <= '0;
      digit_q  <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      digit_q <= digit_d;
      fd_q    <= fd_d;
      if (bus.load) shadow_q <= bus.value;
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.DIGIT      = digit_q;
  assign bus.frame_done = fd_q;
endmodule
